// File: rtl/debug_reg_uart_dumper.sv
// Walks the register-file debug port over x0..x(NUM_REGS-1) and streams each
// 32-bit word out an 8N1 UART line, most significant byte first.
module debug_reg_uart_dumper #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  Debug_Source_select,
  input  logic [31:0] Debug_out,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [1:0]          byte_idx;
  logic [31:0]         word_q;
  logic                fin_q;
  logic                baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // Sequencer: tx, busy and done are registered one cycle behind the state,
  // so the line and the completion pulse stay aligned with each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      baud_cnt            <= '0;
      bit_idx             <= '0;
      byte_idx            <= '0;
      word_q              <= '0;
      fin_q               <= 1'b0;
      Debug_Source_select <= '0;
      tx                  <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      done  <= fin_q;
      fin_q <= 1'b0;
      if (fin_q) begin
        busy <= 1'b0;
      end

      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= word_q[{byte_idx, bit_idx}];
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          // fin_q blocks a restart until done has been presented
          if (start && !fin_q) begin
            state               <= SETTLE;
            busy                <= 1'b1;
            Debug_Source_select <= '0;
          end
        end

        SETTLE: begin
          word_q   <= Debug_out;
          byte_idx <= 2'd3;
          bit_idx  <= '0;
          baud_cnt <= '0;
          state    <= START;
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx != 2'd0) begin
              byte_idx <= byte_idx - 2'd1;
              state    <= START;
            end else if (Debug_Source_select != LAST_REG) begin
              Debug_Source_select <= Debug_Source_select + 5'd1;
              state               <= SETTLE;
            end else begin
              Debug_Source_select <= '0;
              fin_q               <= 1'b1;
              state               <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_uart_dumper.sv
// Directed bench for debug_reg_uart_dumper: records tx/busy/done per cycle
// and decodes the UART stream against a small register-file model.
module tb_debug_reg_uart_dumper;

  localparam int HMAX = 16384;

  logic        clk;
  logic        reset;
  logic        start_a;
  logic        start_b;
  logic [4:0]  sel_a;
  logic [4:0]  sel_b;
  logic [31:0] dbg_a;
  logic [31:0] dbg_b;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic txa_h   [HMAX];
  logic busya_h [HMAX];
  logic donea_h [HMAX];
  logic txb_h   [HMAX];
  logic doneb_h [HMAX];

  logic [7:0] dec_q[$];
  int         dec_t[$];
  int         dec_err;

  debug_reg_uart_dumper #(.CLKS_PER_BIT(4), .NUM_REGS(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .Debug_Source_select(sel_a), .Debug_out(dbg_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  debug_reg_uart_dumper #(.CLKS_PER_BIT(1), .NUM_REGS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .Debug_Source_select(sel_b), .Debug_out(dbg_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  // Register file model: x[i] = i*0x01010101, except x5
  assign dbg_a = (sel_a == 5'd5) ? 32'hDEADBEEF : 32'(sel_a) * 32'h01010101;
  assign dbg_b = (sel_b == 5'd5) ? 32'hDEADBEEF : 32'(sel_b) * 32'h01010101;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Value seen at negedge after edge k is stored at index k
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      txa_h[cyc]   = tx_a;
      busya_h[cyc] = busy_a;
      donea_h[cyc] = done_a;
      txb_h[cyc]   = tx_b;
      doneb_h[cyc] = done_b;
    end
  end

  function automatic logic get_tx(input bit b, input int c);
    if (c < 0 || c >= HMAX) return 1'bx;
    return b ? txb_h[c] : txa_h[c];
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    int r;
    r = k / 4;
    w = (r == 5) ? 32'hDEADBEEF : 32'(r) * 32'h01010101;
    return w[8*(3 - (k % 4)) +: 8];
  endfunction

  task automatic decode(input bit b, input int from, input int to, input int cpb);
    int i;
    logic [7:0] d;
    logic v;
    dec_q.delete();
    dec_t.delete();
    dec_err = 0;
    i = from;
    while (i < to) begin
      if (get_tx(b, i) === 1'b0 && get_tx(b, i - 1) === 1'b1) begin
        d = '0;
        for (int s = 0; s < 10; s++) begin
          v = get_tx(b, i + s * cpb);
          for (int k = 1; k < cpb; k++)
            if (get_tx(b, i + s * cpb + k) !== v) dec_err++;
          if (s == 0 && v !== 1'b0) dec_err++;
          if (s == 9 && v !== 1'b1) dec_err++;
          if (s >= 1 && s <= 8) d[s-1] = v;
        end
        dec_q.push_back(d);
        dec_t.push_back(i);
        i = i + 10 * cpb;
      end else begin
        i++;
      end
    end
  endtask

  task automatic pulse_start(input bit b, output int n);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b need 1", tx_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b need 0", done_a); end
    n_cmp++; if (sel_a !== 5'd0) begin n_bad++; $display("FAIL reset_sel: got %h need 00", sel_a); end
    n_cmp++; if (tx_b !== 1'b1) begin n_bad++; $display("FAIL reset_tx_b: got %b need 1", tx_b); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_dump();
    int n, bad_bytes;
    logic [7:0] e0 [4];
    logic [7:0] e5 [4];
    logic [7:0] e31[4];
    e0  = '{8'h00, 8'h00, 8'h00, 8'h00};
    e5  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    e31 = '{8'h1F, 8'h1F, 8'h1F, 8'h1F};
    pulse_start(1'b0, n);
    while (cyc < n + 5200) @(negedge clk);
    decode(1'b0, n, n + 5200, 4);
    n_cmp++; if (dec_q.size() != 128) begin n_bad++; $display("FAIL dump_count: got %0d need 128", dec_q.size()); end
    n_cmp++; if (dec_err != 0) begin n_bad++; $display("FAIL dump_framing: got %0d errors need 0", dec_err); end
    if (dec_q.size() == 128) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (dec_q[k] !== e0[k]) begin n_bad++; $display("FAIL x0_byte%0d: got %h need %h", k, dec_q[k], e0[k]); end
        n_cmp++; if (dec_q[20+k] !== e5[k]) begin n_bad++; $display("FAIL x5_byte%0d: got %h need %h", k, dec_q[20+k], e5[k]); end
        n_cmp++; if (dec_q[124+k] !== e31[k]) begin n_bad++; $display("FAIL x31_byte%0d: got %h need %h", k, dec_q[124+k], e31[k]); end
      end
      bad_bytes = 0;
      for (int k = 0; k < 128; k++) if (dec_q[k] !== exp_byte(k)) bad_bytes++;
      n_cmp++; if (bad_bytes != 0) begin n_bad++; $display("FAIL dump_all_bytes: got %0d wrong need 0", bad_bytes); end
    end
    test_timing(n);
  endtask

  task automatic test_timing(input int n);
    int dcount, dfirst;
    n_cmp++; if (busya_h[n] !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b need 1", busya_h[n]); end
    n_cmp++; if (txa_h[n+1] !== 1'b1) begin n_bad++; $display("FAIL tx_settle: got %b need 1", txa_h[n+1]); end
    n_cmp++; if (txa_h[n+2] !== 1'b0) begin n_bad++; $display("FAIL tx_fall: got %b need 0", txa_h[n+2]); end
    if (dec_t.size() >= 5) begin
      n_cmp++; if (dec_t[0] != n + 2) begin n_bad++; $display("FAIL first_frame: got %0d need %0d", dec_t[0] - n, 2); end
      n_cmp++; if (dec_t[1] - dec_t[0] != 40) begin n_bad++; $display("FAIL byte_spacing: got %0d need 40", dec_t[1] - dec_t[0]); end
      n_cmp++; if (dec_t[4] - dec_t[3] != 41) begin n_bad++; $display("FAIL reg_spacing: got %0d need 41", dec_t[4] - dec_t[3]); end
    end
    dcount = 0; dfirst = -1;
    for (int c = n; c < n + 5200; c++) if (donea_h[c] === 1'b1) begin dcount++; if (dfirst < 0) dfirst = c; end
    n_cmp++; if (dcount != 1) begin n_bad++; $display("FAIL done_count: got %0d need 1", dcount); end
    n_cmp++; if (dfirst != n + 5153) begin n_bad++; $display("FAIL done_edge: got N+%0d need N+5153", dfirst - n); end
    n_cmp++; if (busya_h[n+5152] !== 1'b1) begin n_bad++; $display("FAIL busy_before_done: got %b need 1", busya_h[n+5152]); end
    n_cmp++; if (busya_h[n+5153] !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b need 0", busya_h[n+5153]); end
    n_cmp++; if (sel_a !== 5'd0) begin n_bad++; $display("FAIL sel_after_dump: got %h need 00", sel_a); end
  endtask

  task automatic test_start_while_busy();
    int n, dcount, dfirst;
    pulse_start(1'b0, n);
    while (cyc < n + 99) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    while (cyc < n + 2999) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    while (cyc < n + 5300) @(negedge clk);
    decode(1'b0, n, n + 5300, 4);
    n_cmp++; if (dec_q.size() != 128) begin n_bad++; $display("FAIL busy_start_count: got %0d need 128", dec_q.size()); end
    dcount = 0; dfirst = -1;
    for (int c = n; c < n + 5300; c++) if (donea_h[c] === 1'b1) begin dcount++; if (dfirst < 0) dfirst = c; end
    n_cmp++; if (dcount != 1) begin n_bad++; $display("FAIL busy_start_done: got %0d need 1", dcount); end
    n_cmp++; if (dfirst != n + 5153) begin n_bad++; $display("FAIL busy_start_edge: got N+%0d need N+5153", dfirst - n); end
  endtask

  task automatic test_reset_mid_dump();
    int n, n2, dcount;
    pulse_start(1'b0, n);
    while (cyc < n + 1657) @(negedge clk);
    n_cmp++; if (tx_a !== 1'b0) begin n_bad++; $display("FAIL x10_bit0_low: got %b need 0", tx_a); end
    n_cmp++; if (sel_a !== 5'd10) begin n_bad++; $display("FAIL x10_select: got %h need 0a", sel_a); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL midreset_tx: got %b need 1", tx_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b need 0", busy_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    dcount = 0;
    for (int c = n; c <= cyc; c++) if (donea_h[c] === 1'b1) dcount++;
    n_cmp++; if (dcount != 0) begin n_bad++; $display("FAIL midreset_done: got %0d pulses need 0", dcount); end
    pulse_start(1'b0, n2);
    while (cyc < n2 + 200) @(negedge clk);
    decode(1'b0, n2, n2 + 200, 4);
    n_cmp++; if (dec_q.size() < 4) begin n_bad++; $display("FAIL restart_count: got %0d need >=4", dec_q.size()); end
    if (dec_q.size() >= 4) begin
      n_cmp++; if ({dec_q[0], dec_q[1], dec_q[2], dec_q[3]} !== 32'h00000000) begin
        n_bad++; $display("FAIL restart_x0: got %h%h%h%h need 00000000", dec_q[0], dec_q[1], dec_q[2], dec_q[3]);
      end
      n_cmp++; if (dec_t[0] != n2 + 2) begin n_bad++; $display("FAIL restart_fall: got N+%0d need N+2", dec_t[0] - n2); end
    end
  endtask

  task automatic test_fast_baud();
    int n, dcount, dfirst;
    logic [7:0] e[8];
    e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
    pulse_start(1'b1, n);
    while (cyc < n + 100) @(negedge clk);
    decode(1'b1, n, n + 100, 1);
    n_cmp++; if (dec_q.size() != 8) begin n_bad++; $display("FAIL fast_count: got %0d need 8", dec_q.size()); end
    n_cmp++; if (txb_h[n+2] !== 1'b0) begin n_bad++; $display("FAIL fast_fall: got %b need 0", txb_h[n+2]); end
    if (dec_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (dec_q[k] !== e[k]) begin n_bad++; $display("FAIL fast_byte%0d: got %h need %h", k, dec_q[k], e[k]); end
      end
    end
    dcount = 0; dfirst = -1;
    for (int c = n; c < n + 100; c++) if (doneb_h[c] === 1'b1) begin dcount++; if (dfirst < 0) dfirst = c; end
    n_cmp++; if (dcount != 1) begin n_bad++; $display("FAIL fast_done_count: got %0d need 1", dcount); end
    n_cmp++; if (dfirst != n + 83) begin n_bad++; $display("FAIL fast_done_edge: got N+%0d need N+83", dfirst - n); end
  endtask

  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    test_reset();
    test_full_dump();
    test_start_while_busy();
    test_reset_mid_dump();
    test_fast_baud();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
